reg_file_mp: RTL and testbench

//   Parametrised multi-read-port register file for the RISC-V core: XLEN-wide, NREGS deep, NUM_RD read ports.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_mp_scoreboard.sv | 52 +++++
 rtl/reg_file_mp.sv | 136 +++++++++++++
 tb/tb_reg_file_mp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    // One byte lane of a byte-enable write; used by both the storage write
    // path and the same-cycle bypass path so the two can never disagree.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, wiped on flush, with NUM_RD lookup ports.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] lk_addr,
    output logic [NUM_RD-1:0]    lk_busy
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Next busy vector: flush beats everything, set beats clear on the same entry.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (clr_en && int'(clr_addr) < NREGS) busy_d[clr_addr] = 1'b0;
            if (set_en && int'(set_addr) < NREGS) busy_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // Busy bits reset clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lk
        logic [AW-1:0] a;
        assign a = lk_addr[k*AW +: AW];
        // Out-of-range lookups report not busy.
        always_comb begin
            lk_busy[k] = 1'b0;
            if (int'(a) < NREGS) lk_busy[k] = busy_q[a];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enable writes, optional write
// bypass, optional hardwired x0, sequenced post-reset clear and a
// pending-write scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [XLEN/8-1:0]      wr_be,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic                   ready
);

    localparam int NB = XLEN / 8;

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] regs [NREGS];

    logic            run;
    logic            wr_ok;
    logic [XLEN-1:0] wr_old, wr_merged;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [NUM_RD-1:0] sb_busy;

    assign run   = (state_q == RF_RUN);
    assign ready = ready_q;

    // A write is live only in RUN, in range, and not aimed at a hardwired x0.
    assign wr_ok = run && wr_en && (int'(wr_addr) < NREGS) &&
                   !(ZERO_REG != 0 && wr_addr == '0);

    // Current contents of the write target, before merging.
    always_comb begin
        wr_old = '0;
        if (int'(wr_addr) < NREGS) wr_old = regs[wr_addr];
    end

    for (genvar b = 0; b < NB; b++) begin : g_merge
        assign wr_merged[8*b +: 8] = byte_merge(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
    end

    // Init sequencer: walk clr_cnt up to NREGS-1, then settle in RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RF_INIT) begin
            if (clr_cnt_q == AW'(NREGS - 1)) state_d = RF_RUN;
            else                             clr_cnt_d = clr_cnt_q + 1'b1;
        end
        ready_d = (state_d == RF_RUN);
    end

    // FSM state, clear counter and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Single storage write port: the clear sequence owns it during INIT.
    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = wr_addr;
        mem_wdata = wr_merged;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end
    end

    // Storage array: no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) regs[mem_waddr] <= mem_wdata;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (run && iss_en),
        .set_addr (iss_addr),
        .clr_en   (run && wr_en),
        .clr_addr (wr_addr),
        .flush    (run && flush),
        .lk_addr  (rd_addr),
        .lk_busy  (sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok, hit;
        assign ra    = rd_addr[k*AW +: AW];
        assign ra_ok = (int'(ra) < NREGS) && !(ZERO_REG != 0 && ra == '0);
        assign hit   = (BYPASS != 0) && wr_ok && (wr_addr == ra);
        // Read mux: zero in INIT or for x0/out-of-range, bypass on a live write hit.
        always_comb begin
            rd_data[k*XLEN +: XLEN] = '0;
            rd_busy[k]              = 1'b0;
            if (run && ra_ok) begin
                rd_data[k*XLEN +: XLEN] = hit ? wr_merged : regs[ra];
                rd_busy[k]              = sb_busy[k] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp with default parameters
// (XLEN=32, NREGS=32, NUM_RD=2, ZERO_REG=1, BYPASS=1).
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  ({ra1, ra0}),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .ready    (ready)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        flush;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;
        logic        b0, b1;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] d0, d1;
        logic        b0, b1;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                                logic ie, logic [4:0] ia, logic fl,
                                logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic b0, logic b1);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
        v.iss_en = ie; v.iss_addr = ia; v.flush = fl;
        v.ra0 = a0; v.ra1 = a1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    // Count rising edges until ready; returns 999 on timeout.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!ready) cycles = 999;
    endtask

    initial begin
        int   cyc;
        exp_t e;

        idle();
        ra0 = 5'd1; ra1 = 5'd2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rd0", rd_data[31:0], 32'd0);
        check("reset_busy", {30'd0, rd_busy}, 32'd0);
        rst = 1'b0;
        wait_ready(cyc);
        check("init_cycles", cyc, 32'd32);

        // Every register reads zero after the clear sequence.
        for (int i = 1; i < 32; i++) begin
            ra0 = 5'(i);
            #1;
            check($sformatf("zero_x%0d", i), rd_data[31:0], 32'd0);
            check($sformatf("zero_busy_x%0d", i), {31'd0, rd_busy[0]}, 32'd0);
        end
        @(posedge clk); #1;

        //              we   wa     wd            be       ie   ia     fl    ra0    ra1    d0            d1            b0 b1
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd1,  5'd2,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 4'hF,    0, 5'd0,  0,   5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(1, 5'd5,  32'h000000AA, 4'b0001, 0, 5'd0,  0,   5'd5,  5'd6,  32'hDEADBEAA, 32'h0,        0, 0));
        vecs.push_back(mk(1, 5'd5,  32'hFFFFFFFF, 4'h0,    0, 5'd0,  0,   5'd5,  5'd6,  32'hDEADBEAA, 32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd5,  5'd6,  32'hDEADBEAA, 32'h0,        0, 0));
        vecs.push_back(mk(1, 5'd6,  32'h11223344, 4'b1010, 0, 5'd0,  0,   5'd5,  5'd6,  32'hDEADBEAA, 32'h11003300, 0, 0));
        vecs.push_back(mk(1, 5'd0,  32'h00001234, 4'hF,    1, 5'd0,  0,   5'd0,  5'd6,  32'h0,        32'h11003300, 0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd0,  5'd0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    1, 5'd7,  0,   5'd7,  5'd0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd7,  5'd0,  32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(1, 5'd7,  32'h00000077, 4'hF,    1, 5'd7,  0,   5'd7,  5'd7,  32'h77,       32'h77,       0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd7,  5'd0,  32'h77,       32'h0,        1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  1,   5'd7,  5'd0,  32'h77,       32'h0,        1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd7,  5'd0,  32'h77,       32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    1, 5'd9,  1,   5'd9,  5'd0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd9,  5'd0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    1, 5'd9,  0,   5'd0,  5'd9,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd9,  5'd0,  32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(1, 5'd9,  32'hFFFFFFFF, 4'h0,    0, 5'd0,  0,   5'd9,  5'd9,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd9,  5'd0,  32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(1, 5'd31, 32'hCAFEF00D, 4'hF,    0, 5'd0,  0,   5'd31, 5'd7,  32'hCAFEF00D, 32'h77,       0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        4'h0,    0, 5'd0,  0,   5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEAA, 0, 0));

        // Drive each vector after an edge, sample the combinational outputs
        // on the falling edge, commit on the next rising edge.
        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            wr_be = vecs[i].wr_be; iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
            flush = vecs[i].flush; ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            e.idx = i; e.d0 = vecs[i].d0; e.d1 = vecs[i].d1; e.b0 = vecs[i].b0; e.b1 = vecs[i].b1;
            sbq.push_back(e);
            @(negedge clk);
            e = sbq.pop_front();
            check($sformatf("v%0d_d0", e.idx), rd_data[31:0], e.d0);
            check($sformatf("v%0d_d1", e.idx), rd_data[63:32], e.d1);
            check($sformatf("v%0d_busy", e.idx), {30'd0, rd_busy}, {30'd0, e.b1, e.b0});
            @(posedge clk); #1;
        end
        idle();

        // Mid-operation reset: contents and busy are wiped, INIT ignores traffic.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; wr_be = 4'hF;
        @(posedge clk); #1;
        idle();
        ra0 = 5'd3; ra1 = 5'd5;
        #1;
        check("x3_written", rd_data[31:0], 32'h55);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99; wr_be = 4'hF;
        iss_en = 1'b1; iss_addr = 5'd3;
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_rd0", rd_data[31:0], 32'd0);
        check("midrst_rd1", rd_data[63:32], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(cyc);
        check("reinit_cycles", cyc, 32'd32);
        idle();
        #1;
        check("reinit_x3", rd_data[31:0], 32'd0);
        check("reinit_x5", rd_data[63:32], 32'd0);
        check("reinit_busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk); #1;
        check("reinit_x3_next", rd_data[31:0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
